quad_decoder: RTL and testbench

Quadrature decoder that consumes the A/B phase pair produced by the team's encoder block, or by a physical encoder, and turns it into a signed position count.

- Synchronises and glitch-filters both phases.
- Decodes each legal Gray-code transition into a ±1 step.
- Flags illegal double-bit jumps.
- Sits directly downstream of the encoder; feeds position/direction to motor-control and display logic.

---
 rtl/quad_pkg.sv | 49 ++++
 rtl/quad_input_filter.sv | 61 ++++++
 rtl/quad_decoder.sv | 120 ++++++++++++
 tb/tb_quad_decoder.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/quad_pkg.sv
// Shared quadrature definitions: phase encodings, direction constants,
// decoder FSM states and the Gray-code step classifier.
package quad_pkg;

  // Phase states in clockwise order, written {A,B}
  localparam logic [1:0] PH_00 = 2'b00;
  localparam logic [1:0] PH_10 = 2'b10;
  localparam logic [1:0] PH_11 = 2'b11;
  localparam logic [1:0] PH_01 = 2'b01;

  localparam logic DIR_CW  = 1'b1;
  localparam logic DIR_CCW = 1'b0;

  typedef enum logic {
    PRIME = 1'b0,
    TRACK = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    DELTA_NONE = 2'd0,
    DELTA_INC  = 2'd1,
    DELTA_DEC  = 2'd2,
    DELTA_ILL  = 2'd3
  } delta_t;

  // Position of a phase state along the clockwise cycle
  function automatic logic [1:0] phase_index(input logic [1:0] ph);
    case (ph)
      PH_00:   return 2'd0;
      PH_10:   return 2'd1;
      PH_11:   return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  // Classify prev->cur: one step forward is +1, one step back is -1,
  // a jump of two positions (both bits flipped) is illegal.
  function automatic delta_t quad_delta(input logic [1:0] prev, input logic [1:0] cur);
    logic [1:0] d;
    d = phase_index(cur) - phase_index(prev);
    case (d)
      2'd0:    return DELTA_NONE;
      2'd1:    return DELTA_INC;
      2'd3:    return DELTA_DEC;
      default: return DELTA_ILL;
    endcase
  endfunction

endpackage

// File: rtl/quad_input_filter.sv
// Two-flop synchroniser for the {A,B} pair followed by a stability filter:
// a new value is accepted only after it has been seen unchanged on the
// synchroniser output for FILTER_LEN consecutive clock edges.
module quad_input_filter import quad_pkg::*; #(
  parameter int FILTER_LEN = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] ab,
  output logic [1:0] filt
);

  localparam int CW = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_LEN = CW'(FILTER_LEN);

  logic [1:0]    r_s1;
  logic [1:0]    r_s2;
  logic [1:0]    r_cand;
  logic [1:0]    r_filt;
  logic [CW-1:0] r_cnt;

  logic          w_run;
  logic          w_same;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_accept;

  // Stability evaluation: continue the run only while the candidate holds
  always_comb begin
    w_run     = (r_s2 != r_filt);
    w_same    = (r_cnt != '0) && (r_s2 == r_cand);
    w_cnt_nxt = w_same ? (r_cnt + CNT_ONE) : CNT_ONE;
    w_accept  = w_run && (w_cnt_nxt == CNT_LEN);
  end

  // Synchroniser chain, candidate tracking and filtered output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1   <= PH_00;
      r_s2   <= PH_00;
      r_cand <= PH_00;
      r_filt <= PH_00;
      r_cnt  <= '0;
    end else begin
      r_s1 <= ab;
      r_s2 <= r_s1;
      if (!w_run) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_filt <= r_s2;
        r_cnt  <= '0;
      end else begin
        r_cnt  <= w_cnt_nxt;
        r_cand <= r_s2;
      end
    end
  end

  assign filt = r_filt;

endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder: conditions the A/B phases, waits for the filter
// pipeline to settle after reset, then turns each legal Gray-code
// transition into a +/-1 position step and counts illegal jumps.
module quad_decoder import quad_pkg::*; #(
  parameter int COUNT_WIDTH = 16,
  parameter int FILTER_LEN  = 1,
  parameter int ERR_WIDTH   = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          A,
  input  logic                          B,
  input  logic                          clear,
  input  logic                          err_clr,
  output logic signed [COUNT_WIDTH-1:0] position,
  output logic                          step,
  output logic                          dir,
  output logic                          error,
  output logic [ERR_WIDTH-1:0]          err_count
);

  // Priming covers the synchroniser and filter latency plus one edge for
  // prev to capture the settled phase, so a phase held through reset is
  // never mistaken for a transition.
  localparam int PRIME_LEN = FILTER_LEN + 2;
  localparam int PCW       = $clog2(PRIME_LEN + 1);
  localparam logic [PCW-1:0] PRIME_LAST = PCW'(PRIME_LEN);
  localparam logic [PCW-1:0] PRIME_ONE  = PCW'(1);

  state_t         r_state;
  logic [PCW-1:0] r_prime_cnt;
  logic [1:0]     r_prev;

  logic [1:0]     w_filt;
  delta_t         w_delta;
  logic           w_track;
  logic           w_inc;
  logic           w_dec;
  logic           w_ill;

  // Saturating increment for the illegal-transition counter
  function automatic logic [ERR_WIDTH-1:0] sat_inc(input logic [ERR_WIDTH-1:0] v);
    return (&v) ? v : (v + ERR_WIDTH'(1));
  endfunction

  quad_input_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_filter (
    .clk   (clk),
    .rst_n (rst_n),
    .ab    ({A, B}),
    .filt  (w_filt)
  );

  // Classify the filtered phase against the previous one
  always_comb begin
    w_delta = quad_delta(r_prev, w_filt);
    w_track = (r_state == TRACK);
    w_inc   = w_track && (w_delta == DELTA_INC);
    w_dec   = w_track && (w_delta == DELTA_DEC);
    w_ill   = w_track && (w_delta == DELTA_ILL);
  end

  // PRIME/TRACK sequencing; prev follows the filtered phase in both states
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= PRIME;
      r_prime_cnt <= '0;
      r_prev      <= PH_00;
    end else begin
      r_prev <= w_filt;
      if (r_state == PRIME) begin
        if (r_prime_cnt == PRIME_LAST) begin
          r_state <= TRACK;
        end else begin
          r_prime_cnt <= r_prime_cnt + PRIME_ONE;
        end
      end
    end
  end

  // Position counter, step pulse and direction; clear wins over a step
  // but the step pulse and direction still reflect the transition
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      position <= '0;
      step     <= 1'b0;
      dir      <= DIR_CW;
    end else begin
      step <= w_inc | w_dec;
      if (w_inc) begin
        dir <= DIR_CW;
      end else if (w_dec) begin
        dir <= DIR_CCW;
      end
      if (clear) begin
        position <= '0;
      end else if (w_inc) begin
        position <= position + COUNT_WIDTH'(1);
      end else if (w_dec) begin
        position <= position - COUNT_WIDTH'(1);
      end
    end
  end

  // Sticky error flag and saturating error count; err_clr wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      error     <= 1'b0;
      err_count <= '0;
    end else if (err_clr) begin
      error     <= 1'b0;
      err_count <= '0;
    end else if (w_ill) begin
      error     <= 1'b1;
      err_count <= sat_inc(err_count);
    end
  end

endmodule

// File: tb/tb_quad_decoder.sv
// Bench for quad_decoder: scoreboard of expected output events checked by a
// negedge monitor, plus direct checks of reset, latency and boundaries.
module tb_quad_decoder;

  typedef struct packed {
    logic        stp;
    logic [15:0] pos;
    logic        dr;
    logic        er;
    logic [7:0]  ec;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic A = 1'b0, B = 1'b0, clear = 1'b0, err_clr = 1'b0;
  logic signed [15:0] position;
  logic step, dir, error;
  logic [7:0] err_count;

  logic A4 = 1'b0, B4 = 1'b0, clear4 = 1'b0, err_clr4 = 1'b0;
  logic signed [15:0] position4;
  logic step4, dir4, error4;
  logic [7:0] err_count4;

  int checks = 0;
  int fails = 0;
  int step_cnt = 0;
  int step4_cnt = 0;
  logic [7:0] last_ec = 8'h00;

  exp_t sb[$];
  logic [1:0] seq [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
  int ci = 0;
  logic [15:0] m_pos = 16'h0000;
  logic m_dir = 1'b1;
  logic m_err = 1'b0;
  logic [7:0] m_ec = 8'h00;
  int s0;

  quad_decoder #(.COUNT_WIDTH(16), .FILTER_LEN(1), .ERR_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .clear(clear), .err_clr(err_clr),
    .position(position), .step(step), .dir(dir), .error(error), .err_count(err_count)
  );

  quad_decoder #(.COUNT_WIDTH(16), .FILTER_LEN(4), .ERR_WIDTH(8)) dut4 (
    .clk(clk), .rst_n(rst_n), .A(A4), .B(B4), .clear(clear4), .err_clr(err_clr4),
    .position(position4), .step(step4), .dir(dir4), .error(error4), .err_count(err_count4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_exp(input logic stp);
    exp_t e;
    e.stp = stp; e.pos = m_pos; e.dr = m_dir; e.er = m_err; e.ec = m_ec;
    sb.push_back(e);
  endtask

  task automatic cw(input int hold);
    ci = (ci + 1) % 4;
    {A, B} = seq[ci];
    m_pos = m_pos + 16'd1;
    m_dir = 1'b1;
    push_exp(1'b1);
    tick(hold);
  endtask

  task automatic ccw(input int hold);
    ci = (ci + 3) % 4;
    {A, B} = seq[ci];
    m_pos = m_pos - 16'd1;
    m_dir = 1'b0;
    push_exp(1'b1);
    tick(hold);
  endtask

  task automatic jump(input int hold);
    ci = (ci + 2) % 4;
    {A, B} = seq[ci];
    m_err = 1'b1;
    if (m_ec != 8'hFF) begin
      m_ec = m_ec + 8'd1;
      push_exp(1'b0);
    end
    tick(hold);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    m_pos = 16'h0000;
  endtask

  // Monitor: every step pulse or err_count change is an output event
  always @(negedge clk) begin
    if (!rst_n) begin
      last_ec = 8'h00;
    end else begin
      if (step) step_cnt++;
      if (step4) step4_cnt++;
      if (step || (err_count != last_ec)) begin
        checks++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL unexpected_event step=%0b pos=%0h ec=%0h want=none", step, position, err_count);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if ({step, position, dir, error, err_count} !== e) begin
            fails++;
            $display("FAIL event got=%0b/%0h/%0b/%0b/%0h want=%0b/%0h/%0b/%0b/%0h",
                     step, position, dir, error, err_count, e.stp, e.pos, e.dr, e.er, e.ec);
          end
        end
      end
      last_ec = err_count;
    end
  end

  initial begin
    // Reset state
    tick(3);
    chk("rst_position", 32'($unsigned(position)), 32'h0);
    chk("rst_step", 32'(step), 32'h0);
    chk("rst_dir", 32'(dir), 32'h1);
    chk("rst_error", 32'(error), 32'h0);
    chk("rst_err_count", 32'(err_count), 32'h0);
    rst_n = 1'b1;
    tick(10);

    // Test 1: clockwise cycle, each state held 4 cycles, with latency check
    s0 = step_cnt;
    cw(0);
    tick(3);
    chk("lat_no_step_k2", 32'(step), 32'h0);
    tick(1);
    chk("lat_step_k3", 32'(step), 32'h1);
    chk("lat_pos_k3", 32'($unsigned(position)), 32'h1);
    cw(4); cw(4); cw(4);
    tick(4);
    chk("t1_position", 32'($unsigned(position)), 32'h4);
    chk("t1_steps", 32'(step_cnt - s0), 32'd4);
    chk("t1_dir", 32'(dir), 32'h1);
    chk("t1_error", 32'(error), 32'h0);

    // Test 2: anticlockwise from 0
    do_clear();
    ccw(4); ccw(4); ccw(4);
    tick(4);
    chk("t2_position", 32'($unsigned(position)), 32'hFFFD);
    chk("t2_dir", 32'(dir), 32'h0);
    ccw(4);
    tick(4);

    // Test 3: wrap both ways, one transition per clock
    do_clear();
    for (int i = 0; i < 32768; i++) cw(1);
    tick(6);
    chk("t3_wrap_up", 32'($unsigned(position)), 32'h8000);
    do_clear();
    ccw(6);
    chk("t3_wrap_down", 32'($unsigned(position)), 32'hFFFF);
    chk("t3_dir", 32'(dir), 32'h0);

    // Test 4: illegal jumps, err_clr, saturation, err_clr beating an illegal
    s0 = step_cnt;
    jump(6);
    chk("t4_error", 32'(error), 32'h1);
    chk("t4_err_count", 32'(err_count), 32'h1);
    chk("t4_pos_kept", 32'($unsigned(position)), 32'hFFFF);
    chk("t4_no_step", 32'(step_cnt - s0), 32'd0);
    m_err = 1'b0; m_ec = 8'h00;
    push_exp(1'b0);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    tick(2);
    chk("t4_clr_error", 32'(error), 32'h0);
    chk("t4_clr_count", 32'(err_count), 32'h0);
    for (int i = 0; i < 300; i++) jump(1);
    tick(6);
    chk("t4_saturate", 32'(err_count), 32'hFF);
    ci = (ci + 2) % 4;
    {A, B} = seq[ci];
    m_err = 1'b0; m_ec = 8'h00;
    push_exp(1'b0);
    tick(3);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    tick(3);
    chk("t4_clr_wins_err", 32'(error), 32'h0);
    chk("t4_clr_wins_cnt", 32'(err_count), 32'h0);

    // Test 6a: clear in the same cycle as a step edge
    ci = (ci + 1) % 4;
    {A, B} = seq[ci];
    m_pos = 16'h0000; m_dir = 1'b1;
    push_exp(1'b1);
    tick(3);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    chk("t6_clear_pos", 32'($unsigned(position)), 32'h0);
    chk("t6_clear_step", 32'(step), 32'h1);
    tick(2);

    // Test 6b: asynchronous reset mid-operation with position 5
    cw(2); cw(2); cw(2); cw(2); cw(2);
    tick(6);
    chk("t6_pre_reset", 32'($unsigned(position)), 32'h5);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_position", 32'($unsigned(position)), 32'h0);
    chk("t6_rst_step", 32'(step), 32'h0);
    chk("t6_rst_dir", 32'(dir), 32'h1);
    chk("t6_rst_error", 32'(error), 32'h0);
    chk("t6_rst_err_count", 32'(err_count), 32'h0);
    {A, B} = 2'b11;
    ci = 2; m_pos = 16'h0000; m_dir = 1'b1; m_err = 1'b0; m_ec = 8'h00;
    tick(3);
    rst_n = 1'b1;
    tick(12);
    chk("t6_held11_error", 32'(error), 32'h0);
    chk("t6_held11_position", 32'($unsigned(position)), 32'h0);

    // Test 5: FILTER_LEN=4 glitch rejection and acceptance latency
    s0 = step4_cnt;
    A4 = 1'b1;
    tick(3);
    A4 = 1'b0;
    tick(12);
    chk("t5_glitch_pos", 32'($unsigned(position4)), 32'h0);
    chk("t5_glitch_steps", 32'(step4_cnt - s0), 32'd0);
    A4 = 1'b1;
    tick(6);
    chk("t5_pos_k5", 32'($unsigned(position4)), 32'h0);
    tick(1);
    chk("t5_pos_k6", 32'($unsigned(position4)), 32'h1);
    chk("t5_step_k6", 32'(step4), 32'h1);
    chk("t5_dir", 32'(dir4), 32'h1);
    chk("t5_error", 32'(error4), 32'h0);
    chk("t5_err_count", 32'(err_count4), 32'h0);

    tick(4);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
